// File: rtl/msg_rx_framer_if.sv
// Byte strobes from the UART receiver and the message / strobe bundle
// presented to the command dispatcher.
interface msg_rx_framer_if #(
   parameter int MAX_LEN = 60
);
   logic [7:0]               rx_byte;
   logic                     rx_valid;
   logic                     msg_valid;
   logic                     msg_ready;
   logic [7:0]               msg_type;
   logic [7:0]               msg_len;
   logic [8*(MAX_LEN-8)-1:0] msg_payload;
   logic                     ping;
   logic                     invalid;
   logic                     overrun;

   modport master (
      input  rx_byte, rx_valid, msg_ready,
      output msg_valid, msg_type, msg_len, msg_payload, ping, invalid, overrun
   );

   modport slave (
      output rx_byte, rx_valid, msg_ready,
      input  msg_valid, msg_type, msg_len, msg_payload, ping, invalid, overrun
   );
endinterface

// File: rtl/msg_rx_framer.sv
// Frames length-prefixed, CRC-32 protected messages from a byte stream and
// reports PING / INVALID strobes; inter-byte timeouts resynchronise the stream.
module msg_rx_framer #(
   parameter int MAX_LEN        = 60,
   parameter int TIMEOUT_CYCLES = 2048
) (
   input logic             comm_clk,
   input logic             reset,
   msg_rx_framer_if.master bus
);
   localparam int PL_BYTES = MAX_LEN - 8;
   localparam int PL_BITS  = 8 * PL_BYTES;
   localparam int GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_HIT = GAP_W'(TIMEOUT_CYCLES - 2);
   localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(TIMEOUT_CYCLES);
   localparam logic [23:0]      LEN_MAX = 24'(MAX_LEN);

   typedef enum logic [2:0] { IDLE, HDR, BODY, CRC, HOLD, DISCARD } state_t;

   state_t             state, state_next;
   logic [23:0]        len, count;
   logic [31:0]        crc;
   logic [23:0]        rx_crc;
   logic [GAP_W-1:0]   gap;
   logic [PL_BITS-1:0] payload;
   logic [7:0]         msg_type, msg_len;
   logic               msg_valid, ping, invalid, overrun;

   logic        ping_next, invalid_next, valid_set, valid_clr, overrun_set;
   logic        frame_start, take_byte, crc_upd, crc_shift, hdr_wr, type_wr, store_en;
   logic        timeout_hit, gap_run;
   logic [23:0] store_idx;
   logic [31:0] crc_word;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   // The timeout fires one cycle early on the counter so the registered pulse
   // lands TIMEOUT_CYCLES cycles after the last strobe, like the other strobes.
   assign timeout_hit = (gap == GAP_HIT);
   assign gap_run     = (state == HDR) || (state == BODY) || (state == CRC) || (state == DISCARD);
   assign crc_word    = {rx_crc, bus.rx_byte};
   assign store_idx   = count - 24'd4;

   always_comb begin
      state_next   = state;
      ping_next    = 1'b0;
      invalid_next = 1'b0;
      valid_set    = 1'b0;
      valid_clr    = 1'b0;
      overrun_set  = 1'b0;
      frame_start  = 1'b0;
      take_byte    = 1'b0;
      crc_upd      = 1'b0;
      crc_shift    = 1'b0;
      hdr_wr       = 1'b0;
      type_wr      = 1'b0;
      store_en     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_valid) begin
               if (bus.rx_byte == 8'h00) begin
                  ping_next = 1'b1;
               end else if (bus.rx_byte < 8'h08) begin
                  invalid_next = 1'b1;
               end else begin
                  frame_start = 1'b1;
                  state_next  = HDR;
               end
            end
         end
         HDR: begin
            if (bus.rx_valid) begin
               take_byte = 1'b1;
               crc_upd   = 1'b1;
               hdr_wr    = 1'b1;
               if (count == 24'd2 && {bus.rx_byte, len[15:0]} > LEN_MAX) begin
                  invalid_next = 1'b1;
                  state_next   = DISCARD;
               end else if (count == 24'd3) begin
                  type_wr    = 1'b1;
                  state_next = (len == 24'd8) ? CRC : BODY;
               end
            end else if (timeout_hit) begin
               invalid_next = 1'b1;
               state_next   = IDLE;
            end
         end
         BODY: begin
            if (bus.rx_valid) begin
               take_byte = 1'b1;
               crc_upd   = 1'b1;
               store_en  = 1'b1;
               if (count + 24'd1 == len - 24'd4) begin
                  state_next = CRC;
               end
            end else if (timeout_hit) begin
               invalid_next = 1'b1;
               state_next   = IDLE;
            end
         end
         CRC: begin
            if (bus.rx_valid) begin
               take_byte = 1'b1;
               crc_shift = 1'b1;
               if (count == len - 24'd1) begin
                  if (crc_word == ~crc) begin
                     valid_set  = 1'b1;
                     state_next = HOLD;
                  end else begin
                     invalid_next = 1'b1;
                     state_next   = IDLE;
                  end
               end
            end else if (timeout_hit) begin
               invalid_next = 1'b1;
               state_next   = IDLE;
            end
         end
         HOLD: begin
            if (bus.rx_valid) begin
               overrun_set = 1'b1;
            end
            if (msg_valid && bus.msg_ready) begin
               valid_clr  = 1'b1;
               state_next = IDLE;
            end
         end
         DISCARD: begin
            if (!bus.rx_valid && timeout_hit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge comm_clk) begin
      if (reset) begin
         state     <= IDLE;
         len       <= '0;
         count     <= '0;
         crc       <= '0;
         rx_crc    <= '0;
         gap       <= '0;
         payload   <= '0;
         msg_type  <= '0;
         msg_len   <= '0;
         msg_valid <= 1'b0;
         ping      <= 1'b0;
         invalid   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state   <= state_next;
         ping    <= ping_next;
         invalid <= invalid_next;
         if (valid_set) begin
            msg_valid <= 1'b1;
         end else if (valid_clr) begin
            msg_valid <= 1'b0;
         end
         if (overrun_set) begin
            overrun <= 1'b1;
         end
         if (bus.rx_valid) begin
            gap <= '0;
         end else if (gap_run && gap != GAP_SAT) begin
            gap <= gap + GAP_W'(1);
         end
         if (frame_start) begin
            len     <= {16'd0, bus.rx_byte};
            count   <= 24'd1;
            crc     <= crc_step(32'hFFFFFFFF, bus.rx_byte);
            payload <= '0;
         end else begin
            if (take_byte) begin
               count <= count + 24'd1;
            end
            if (crc_upd) begin
               crc <= crc_step(crc, bus.rx_byte);
            end
            if (hdr_wr && count == 24'd1) begin
               len[15:8] <= bus.rx_byte;
            end
            if (hdr_wr && count == 24'd2) begin
               len[23:16] <= bus.rx_byte;
            end
            for (int k = 0; k < PL_BYTES; k++) begin
               if (store_en && store_idx == 24'(k)) begin
                  payload[8*k +: 8] <= bus.rx_byte;
               end
            end
         end
         if (crc_shift) begin
            rx_crc <= crc_word[23:0];
         end
         if (type_wr) begin
            msg_type <= bus.rx_byte;
            msg_len  <= len[7:0];
         end
      end
   end

   assign bus.msg_valid   = msg_valid;
   assign bus.msg_type    = msg_type;
   assign bus.msg_len     = msg_len;
   assign bus.msg_payload = payload;
   assign bus.ping        = ping;
   assign bus.invalid     = invalid;
   assign bus.overrun     = overrun;
endmodule
